// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide stage: one result bit per clock.
// Shift-add multiply, restoring divide, shared (2*WIDTH+1)-bit accumulator.
module muldiv_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             OP,
    input  logic [WIDTH-1:0] INA,
    input  logic [WIDTH-1:0] INB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RLO,
    output logic [WIDTH-1:0] RHI,
    output logic             DZ,
    output logic             ZF
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   rlo_q, rlo_d, rhi_q, rhi_d;
    logic               dz_q, dz_d, zf_q, zf_d;

    logic [WIDTH:0]     mul_sum, mul_hi;
    logic [2*WIDTH:0]   mul_next, div_sh, div_next;
    logic [WIDTH+1:0]   div_diff;

    // MUL: acc = {partial (WIDTH+1), multiplier (WIDTH)}; opnd_q holds the multiplicand.
    always_comb begin
        mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, opnd_q};
        mul_hi   = acc_q[0] ? mul_sum : acc_q[2*WIDTH:WIDTH];
        mul_next = {1'b0, mul_hi, acc_q[WIDTH-1:1]};
    end

    // DIV: acc = {0, remainder, dividend/quotient}; opnd_q holds the divisor.
    // The extra top bit of div_diff is the borrow.
    always_comb begin
        div_sh   = {acc_q[2*WIDTH-1:0], 1'b0};
        div_diff = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, opnd_q};
        div_next = div_diff[WIDTH+1] ? div_sh
                                     : {div_diff[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        rlo_d   = rlo_q;
        rhi_d   = rhi_q;
        dz_d    = dz_q;
        zf_d    = zf_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    op_d  = OP;
                    cnt_d = CW'(WIDTH);
                    if (OP) begin
                        acc_d  = {{(WIDTH+1){1'b0}}, INA};
                        opnd_d = INB;
                    end else begin
                        acc_d  = {{(WIDTH+1){1'b0}}, INB};
                        opnd_d = INA;
                    end
                    if (OP && (INB == '0)) begin
                        state_d = StFin;
                        rlo_d   = '1;
                        rhi_d   = INA;
                        dz_d    = 1'b1;
                        zf_d    = 1'b0;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (cnt_q == '0) begin
                    state_d = StFin;
                    rlo_d   = acc_q[WIDTH-1:0];
                    rhi_d   = acc_q[2*WIDTH-1:WIDTH];
                    dz_d    = 1'b0;
                    zf_d    = op_q ? (acc_q[WIDTH-1:0] == '0) : (acc_q[2*WIDTH-1:0] == '0);
                end else begin
                    acc_d = op_q ? div_next : mul_next;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= 1'b0;
            rlo_q   <= '0;
            rhi_q   <= '0;
            dz_q    <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            rlo_q   <= rlo_d;
            rhi_q   <= rhi_d;
            dz_q    <= dz_d;
            zf_q    <= zf_d;
        end
    end

    assign BUSY = (state_q == StRun);
    assign DONE = (state_q == StFin);
    assign RLO  = rlo_q;
    assign RHI  = rhi_q;
    assign DZ   = dz_q;
    assign ZF   = zf_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: plain-arithmetic reference model, expected results
// queued at issue and checked by an independent DONE monitor.
module tb_muldiv_unit;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         START = 1'b0;
    logic         OP = 1'b0;
    logic [W-1:0] INA = '0;
    logic [W-1:0] INB = '0;
    logic         BUSY, DONE, DZ, ZF;
    logic [W-1:0] RLO, RHI;

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .OP    (OP),
        .INA   (INA),
        .INB   (INB),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .RLO   (RLO),
        .RHI   (RHI),
        .DZ    (DZ),
        .ZF    (ZF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        logic         zf;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   sim_done = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: unsigned arithmetic straight from the operation definitions.
    function automatic exp_t model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int c);
        exp_t e;
        logic [2*W-1:0] p;
        if (!op) begin
            p     = 16'(a) * 16'(b);
            e.lo  = p[W-1:0];
            e.hi  = p[2*W-1:W];
            e.dz  = 1'b0;
            e.zf  = (p == 0);
            e.cyc = c + W + 2;
        end else if (b == 0) begin
            e.lo  = '1;
            e.hi  = a;
            e.dz  = 1'b1;
            e.zf  = 1'b0;
            e.cyc = c + 1;
        end else begin
            e.lo  = a / b;
            e.hi  = a % b;
            e.dz  = 1'b0;
            e.zf  = ((a / b) == 0);
            e.cyc = c + W + 2;
        end
        return e;
    endfunction

    // Monitor: every DONE must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        while (!sim_done) begin
            @(negedge CLK);
            if (DONE) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 16'(DONE), 16'h0);
                end else begin
                    e = sb.pop_front();
                    chk("rlo", 16'(RLO), 16'(e.lo));
                    chk("rhi", 16'(RHI), 16'(e.hi));
                    chk("dz", 16'(DZ), 16'(e.dz));
                    chk("zf", 16'(ZF), 16'(e.zf));
                    chk("done_cycle", 16'(cyc), 16'(e.cyc));
                    chk("busy_at_done", 16'(BUSY), 16'h0);
                end
            end
        end
    end

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (DONE) seen = 1;
        end
        if (!seen) chk("done_timeout", 16'h0, 16'h1);
    endtask

    // Issue at the next falling edge, so back-to-back calls start in the cycle after DONE.
    task automatic issue(input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit dzp;
        @(negedge CLK);
        START = 1'b1;
        OP    = op;
        INA   = a;
        INB   = b;
        sb.push_back(model(op, a, b, cyc));
        dzp = op && (b == 0);
        @(negedge CLK);
        START = 1'b0;
        INA   = W'($urandom);
        INB   = W'($urandom);
        chk("busy_after_start", 16'(BUSY), dzp ? 16'h0 : 16'h1);
        if (!dzp) wait_done();
    endtask

    initial begin
        logic [W-1:0] a, b;
        bit           op;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        chk("reset_busy", 16'(BUSY), 16'h0);
        chk("reset_done", 16'(DONE), 16'h0);
        chk("reset_rlo", 16'(RLO), 16'h0);
        chk("reset_rhi", 16'(RHI), 16'h0);
        chk("reset_dz", 16'(DZ), 16'h0);
        chk("reset_zf", 16'(ZF), 16'h0);

        issue(1'b0, 8'h0D, 8'h0B);
        issue(1'b0, 8'hFF, 8'hFF);
        issue(1'b0, 8'h00, 8'h37);
        issue(1'b1, 8'hC8, 8'h07);
        issue(1'b1, 8'h03, 8'h09);
        issue(1'b1, 8'h5A, 8'h00);
        issue(1'b1, 8'h64, 8'h0A);
        issue(1'b1, 8'hFF, 8'h01);

        // Second START mid-run must be ignored; operands must be the captured ones.
        @(negedge CLK);
        START = 1'b1; OP = 1'b0; INA = 8'h9C; INB = 8'h3B;
        sb.push_back(model(1'b0, 8'h9C, 8'h3B, cyc));
        @(negedge CLK);
        START = 1'b0; INA = 8'h00; INB = 8'h00;
        repeat (2) @(negedge CLK);
        START = 1'b1; OP = 1'b1; INA = 8'h11; INB = 8'h22;
        @(negedge CLK);
        START = 1'b0; INA = 8'hA5; INB = 8'h5A;
        wait_done();
        issue(1'b1, 8'hE1, 8'h0F);

        // Reset during a divide: aborted, no DONE afterwards.
        @(negedge CLK);
        START = 1'b1; OP = 1'b1; INA = 8'hE7; INB = 8'h05;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("abort_busy", 16'(BUSY), 16'h0);
        chk("abort_done", 16'(DONE), 16'h0);
        chk("abort_rlo", 16'(RLO), 16'h0);
        chk("abort_rhi", 16'(RHI), 16'h0);
        chk("abort_dz", 16'(DZ), 16'h0);
        chk("abort_zf", 16'(ZF), 16'h0);
        repeat (15) @(negedge CLK);

        for (int i = 0; i < 60; i++) begin
            op = 1'($urandom);
            a  = W'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            issue(op, a, b);
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", 16'(sb.size()), 16'h0);
        sim_done = 1;
        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 8-bit unsigned multiply/divide execution stage, directly downstream of the main register file.
- Consumes the two register-file read buses (operand A from OUTA, operand B from OUTB) and produces a 16-bit product, or a quotient/remainder pair.
- Control sequencer drives START/OP and writes RLO/RHI back through the register-file write port when DONE pulses.
- One bit of the result is computed per clock, using shift-add for multiply and restoring division for divide.

Parameters:
WIDTH, 8, operand width in bits; iteration count = WIDTH; counter width = clog2(WIDTH)+1

Ports:
CLK    input   1      system clock, rising edge
RESET  input   1      synchronous, active-high reset
START  input   1      request operation; sampled only in IDLE
OP     input   1      0 = unsigned multiply, 1 = unsigned divide
INA    input   WIDTH  operand A (multiplicand / dividend), from register-file OUTA
INB    input   WIDTH  operand B (multiplier / divisor), from register-file OUTB
BUSY   output  1      high while an operation is in progress (RUN state)
DONE   output  1      one-cycle pulse; RLO/RHI/DZ/ZF valid and stable from this cycle
RLO    output  WIDTH  MUL: product low byte; DIV: quotient
RHI    output  WIDTH  MUL: product high byte; DIV: remainder
DZ     output  1      divide-by-zero flag for the last completed operation
ZF     output  1      zero flag: MUL {RHI,RLO}==0; DIV quotient==0

Behaviour:
- Interface: one clock (CLK); synchronous, active-high reset (RESET).
- Reset: state=IDLE; BUSY, DONE, DZ and ZF = 0; RLO and RHI = 0; internal accumulator, shift registers and counter cleared.
- Reset mid-operation: the operation aborts with no DONE pulse, and all outputs return to reset values on the same edge.
- Reset has priority over START.
- States: IDLE, RUN, FIN.
- IDLE:
  - On an edge with START=1, latch INA, INB and OP into internal registers, load counter=WIDTH and clear the partial accumulator.
  - If OP=1 and INB==0, go to FIN (divide-by-zero path). Otherwise go to RUN.
  - With START=0, stay in IDLE.
- RUN: one iteration per edge; decrement the counter; when the counter reaches 0 on an edge, go to FIN.
- RUN, MUL iteration: if multiplier LSB=1, add multiplicand to the upper half of the (2*WIDTH+1)-bit accumulator. Then shift the accumulator right by 1, with the multiplier shifting through the low half.
- RUN, DIV iteration (restoring):
  - Shift {remainder, dividend} left by 1, then compute trial = remainder - divisor.
  - If no borrow, remainder = trial and quotient bit = 1; else quotient bit = 0.
  - The subtraction is WIDTH+1 bits wide so the borrow is explicit.
- Transition into FIN:
  - Register RLO and RHI on the same edge that enters FIN.
  - DONE=1 and BUSY=0 for exactly one cycle.
  - DZ=0 unless on the divide-by-zero path; ZF updated.
  - The next edge returns to IDLE with DONE=0.
- Divide by zero: RLO=all ones, RHI=INA, DZ=1, ZF=0. Latency is START edge -> FIN on the next edge, so DONE is high in the cycle after the START edge.
- Latency (normal): START sampled at edge 0; iterations on edges 1..WIDTH; FIN entered on edge WIDTH+1. DONE is therefore high during the cycle after edge 9 (WIDTH=8).
- BUSY is high from after edge 0 until FIN is entered.
- START while in RUN or FIN is ignored and not queued. START high in the cycle after DONE (state IDLE) is accepted.
- Operand capture: INA and INB are latched at START. Changes on the register-file buses during RUN have no effect.
- Result hold: RLO, RHI, DZ and ZF keep their values until the next FIN or reset. DONE is a pulse only.
- All arithmetic is unsigned, with no overflow: the product fits in 2*WIDTH bits, quotient <= INA, remainder < INB.

Test Plan:
- Reset, then START OP=0 with INA=0x0D, INB=0x0B -> BUSY=1 for 9 cycles; DONE pulse on the cycle after edge 9; RHI=0x00, RLO=0x8F, ZF=0, DZ=0.
- MUL INA=0xFF, INB=0xFF -> RHI=0xFE, RLO=0x01. Then MUL INA=0x00, INB=0x37 -> RHI=0x00, RLO=0x00, ZF=1.
- DIV INA=0xC8, INB=0x07 -> RLO=0x1C, RHI=0x04, DZ=0. Then DIV INA=0x03, INB=0x09 -> RLO=0x00, RHI=0x03, ZF=1.
- DIV INA=0x5A, INB=0x00 -> DONE in the cycle after the START edge; RLO=0xFF, RHI=0x5A, DZ=1. A following valid DIV clears DZ.
- START MUL, pulse START again with different operands at iteration 3, change INA/INB mid-run -> result uses the original operands and exactly one DONE is produced. A START asserted in the cycle after DONE begins a new operation.
- Assert RESET at iteration 4 of a DIV -> next cycle BUSY=0, DONE=0, RLO=RHI=0x00, DZ=ZF=0; no DONE pulse follows.
